// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RUN,
    ARB_ZERO,
    ARB_RESP
  } arb_state_t;

  // Quotient returned for a zero divisor; the Divider is bypassed in that case.
  localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set req bit at or after rr_ptr, searching circularly upward.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int unsigned PW = IDX_W + 1;

  logic [PW-1:0] pos;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = pos[IDX_W-1:0];
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative Divider among NUM_REQ exec elements.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       busy,
  output logic [WIDTH-1:0]           div_a,
  output logic [WIDTH-1:0]           div_b,
  output logic                       div_enabled,
  input  logic [WIDTH-1:0]           div_c,
  input  logic                       div_completed
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d, owner, owner_d, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt, resp_valid_d;
  logic [WIDTH-1:0]   a_sel, b_sel, div_a_d, div_b_d, resp_data_d;
  logic               div_enabled_d;
  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  assign a_sel = a_arr[pick_idx];
  assign b_sel = b_arr[pick_idx];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (pick_gnt),
    .grant_idx (pick_idx)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_d;
  end

  // Next state; flush overrides every transition
  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: if (|pick_gnt) state_d = (b_sel == '0) ? ARB_ZERO : ARB_RUN;
        ARB_RUN:  if (div_completed) state_d = ARB_RESP;
        ARB_ZERO: state_d = ARB_RESP;
        ARB_RESP: state_d = ARB_IDLE;
        default:  state_d = ARB_IDLE;
      endcase
    end
  end

  // Grant, busy and next values of the registered outputs
  always_comb begin
    grant         = '0;
    busy          = (state != ARB_IDLE);
    rr_ptr_d      = rr_ptr;
    owner_d       = owner;
    div_a_d       = div_a;
    div_b_d       = div_b;
    div_enabled_d = div_enabled;
    resp_valid_d  = '0;
    resp_data_d   = resp_data;
    if (flush) begin
      div_enabled_d = 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          grant = pick_gnt;
          if (|pick_gnt) begin
            owner_d       = pick_idx;
            div_a_d       = a_sel;
            div_b_d       = b_sel;
            rr_ptr_d      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            div_enabled_d = (b_sel != '0);
          end
        end
        ARB_RUN: begin
          if (div_completed) begin
            resp_data_d   = div_c;
            div_enabled_d = 1'b0;
            resp_valid_d  = NUM_REQ'(1) << owner;
          end
        end
        ARB_ZERO: begin
          resp_data_d  = WIDTH'(DIV_ZERO_RESULT);
          resp_valid_d = NUM_REQ'(1) << owner;
        end
        default: ;
      endcase
    end
  end

  // Operand, result and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      owner       <= '0;
      div_a       <= '0;
      div_b       <= '0;
      div_enabled <= 1'b0;
      resp_valid  <= '0;
      resp_data   <= '0;
    end else begin
      rr_ptr      <= rr_ptr_d;
      owner       <= owner_d;
      div_a       <= div_a_d;
      div_b       <= div_b_d;
      div_enabled <= div_enabled_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a transaction-level reference model and a Divider model.
module tb_div_arbiter;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic [NR-1:0]   grant, resp_valid;
  logic [W-1:0]    resp_data, div_a, div_b;
  logic            busy, div_enabled;
  logic [W-1:0]    div_c = '0;
  logic            div_completed = 1'b0;

  logic force_done = 1'b0;
  int   dcnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   glog[$];
  int   rlog[$];
  logic log_on = 1'b0;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  div_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .req           (req),
    .req_a         (req_a),
    .req_b         (req_b),
    .grant         (grant),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .busy          (busy),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_enabled   (div_enabled),
    .div_c         (div_c),
    .div_completed (div_completed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int start);
    for (int k = 0; k < NR; k++)
      if (r[(start + k) % NR]) return (start + k) % NR;
    return -1;
  endfunction

  // Divider model: completes on the LAT-th consecutive enabled cycle
  always @(posedge clk) begin
    #2;
    if (div_enabled) dcnt = dcnt + 1;
    else             dcnt = 0;
    div_completed = (div_enabled && dcnt == LAT) || force_done;
    div_c = (div_b != '0) ? W'($signed(div_a) / $signed(div_b)) : '0;
  end

  // Reference model: an operation is scheduled by its response cycle
  int            cyc = 0;
  bit            m_active, m_en;
  int            m_owner, m_rr, m_resp_at, m_w;
  logic [W-1:0]  m_data, m_pend, m_da, m_db;
  logic [NR-1:0] m_eg, m_erv;

  always @(negedge clk) begin
    if (!reset) begin
      m_active = 0; m_en = 0; m_rr = 0; m_owner = 0; m_resp_at = -1;
      m_data = '0; m_da = '0; m_db = '0; m_pend = '0;
    end
    m_w   = (!m_active && !flush) ? pick(req, m_rr) : -1;
    m_eg  = (m_w >= 0) ? (NR'(1) << m_w) : '0;
    m_erv = (reset && m_resp_at == cyc) ? (NR'(1) << m_owner) : '0;
    chk("grant", 64'(grant), 64'(m_eg));
    chk("resp_valid", 64'(resp_valid), 64'(m_erv));
    chk("resp_data", 64'(resp_data), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_active));
    chk("div_enabled", 64'(div_enabled), 64'(m_en));
    chk("div_a", 64'(div_a), 64'(m_da));
    chk("div_b", 64'(div_b), 64'(m_db));
    if (log_on && m_w >= 0) glog.push_back(m_w);
    if (log_on && m_erv != '0) rlog.push_back(m_owner);
    if (reset) begin
      if (flush) begin
        m_active = 0; m_en = 0; m_resp_at = -1;
      end else if (!m_active) begin
        if (m_w >= 0) begin
          m_owner  = m_w;
          m_da     = req_a[m_w*W +: W];
          m_db     = req_b[m_w*W +: W];
          m_rr     = (m_w + 1) % NR;
          m_active = 1;
          if (m_db == '0) begin
            m_pend    = 32'hFFFF_FFFF;
            m_resp_at = cyc + 2;
          end else begin
            m_en = 1;
          end
        end
      end else if (m_resp_at == cyc) begin
        m_active  = 0;
        m_resp_at = -1;
      end else if (m_en && div_completed) begin
        m_pend    = div_c;
        m_resp_at = cyc + 1;
        m_en      = 0;
      end
      if (m_resp_at == cyc + 1) m_data = m_pend;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_resp(output logic [NR-1:0] rv, output logic [W-1:0] d, output int n,
                           output logic en_seen, output logic en_last);
    rv = '0; d = '0; n = 0; en_seen = 1'b0; en_last = 1'b0;
    while (n < 60 && rv == '0) begin
      @(negedge clk);
      n++;
      en_seen = en_seen | div_enabled;
      en_last = div_enabled;
      if (resp_valid != '0) begin
        rv = resp_valid;
        d  = resp_data;
      end
    end
    chk("resp_seen", 64'(rv != '0), 64'd1);
  endtask

  initial begin
    logic [NR-1:0] rv;
    logic [W-1:0]  d;
    int            n, seen;
    logic          en_seen, en_last;

    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // Reset asserted mid-RUN drops the outputs without waiting for a clock
    tick(); set_slot(1, 50, 5); req = 4'b0010;
    tick(); req = '0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_div_enabled", 64'(div_enabled), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    tick(); tick(); reset = 1'b1;

    // First grant after reset goes to slot 0; 100/7 returns 14
    set_slot(0, 100, 7); req = 4'b0011;
    @(negedge clk); chk("first_grant", 64'(grant), 64'h1);
    @(posedge clk); #1; req = '0;
    wait_resp(rv, d, n, en_seen, en_last);
    chk("t2_resp_valid", 64'(rv), 64'h1);
    chk("t2_resp_data", 64'(d), 64'd14);
    chk("t2_en_in_resp", 64'(en_last), 64'd0);
    chk("t2_latency", 64'(n), 64'd6);
    @(negedge clk); chk("t2_one_cycle", 64'(resp_valid), 64'h0);

    // Zero divisor bypasses the Divider
    @(posedge clk); #1; set_slot(2, 55, 0); req = 4'b0100;
    @(negedge clk); chk("t4_grant", 64'(grant), 64'h4);
    @(posedge clk); #1; req = '0;
    wait_resp(rv, d, n, en_seen, en_last);
    chk("t4_resp_valid", 64'(rv), 64'h4);
    chk("t4_resp_data", 64'(d), 64'hFFFF_FFFF);
    chk("t4_latency", 64'(n), 64'd2);
    chk("t4_no_enable", 64'(en_seen), 64'd0);

    // Flush in the second RUN cycle cancels with no response
    @(posedge clk); #1; set_slot(3, 1000, 10); req = 4'b1000;
    @(negedge clk); chk("t5_grant", 64'(grant), 64'h8);
    @(posedge clk); #1; req = '0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_div_enabled", 64'(div_enabled), 64'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid != '0) seen++;
    end
    chk("t5_no_resp", 64'(seen), 64'd0);

    // All four requesting: strict rotation starting from the pointer left by the flushed op
    for (int i = 0; i < NR; i++) set_slot(i, W'(30 + i), 3);
    glog.delete(); rlog.delete();
    @(posedge clk); #1; log_on = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp(rv, d, n, en_seen, en_last);
      chk("t3_resp_valid", 64'(rv), 64'(NR'(1) << (k % NR)));
      chk("t3_resp_data", 64'(d), 64'((30 + k % NR) / 3));
    end
    @(posedge clk); #1; req = '0; log_on = 1'b0;
    chk("t3_grant_count", 64'(glog.size()), 64'd5);
    chk("t3_resp_count", 64'(rlog.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < glog.size()) chk("t3_grant_order", 64'(glog[k]), 64'(exp_order[k]));
      if (k < rlog.size()) chk("t3_resp_order", 64'(rlog[k]), 64'(exp_order[k]));
    end

    // Stray completion while idle is ignored; nothing requested stays quiet
    force_done = 1'b1;
    @(posedge clk); #1; force_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t6_grant", 64'(grant), 64'h0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_div_enabled", 64'(div_enabled), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
